// File: rtl/exe_stage.sv
// Execute stage: one-cycle ALU, serial shifter that stalls upstream, and the EXE/MEM register.
// Define SHIFT_FAST_EN to replace the serial shifter with a single-cycle barrel shifter.
module exe_stage #(
  parameter int SHIFT_STEP = 1
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        exe_wreg,
  input  logic        exe_m2reg,
  input  logic        exe_wmem,
  input  logic [2:0]  exe_aluc,
  input  logic        exe_aluimm,
  input  logic [31:0] exe_a,
  input  logic [31:0] exe_b,
  input  logic [31:0] exe_imm,
  input  logic [4:0]  exe_rn,
  input  logic        exe_shift,
  input  logic        exe_wz,
  output logic        exe_stall,
  output logic        mem_wreg,
  output logic        mem_m2reg,
  output logic        mem_wmem,
  output logic [31:0] mem_alu,
  output logic [31:0] mem_b,
  output logic [4:0]  mem_rn,
  output logic        z,
  output logic [1:0]  dbg_state_o
);

  logic [4:0]  shamt;
  logic [31:0] opb;
  logic [31:0] alu_res;

  assign shamt = exe_imm[10:6];
  assign opb   = exe_aluimm ? exe_imm : exe_b;

  always_comb begin
    alu_res = 32'd0;
    case (exe_aluc)
      3'b000:  alu_res = exe_a + opb;
      3'b001:  alu_res = exe_a - opb;
      3'b010:  alu_res = exe_a & opb;
      3'b011:  alu_res = exe_a | opb;
      3'b100:  alu_res = exe_a ^ opb;
      3'b101:  alu_res = {opb[15:0], 16'h0000};
`ifdef SHIFT_FAST_EN
      3'b110:  alu_res = exe_b << shamt;
      3'b111:  alu_res = exe_b >> shamt;
`else
      // Only a zero-distance shift reaches the ALU here, so B passes straight through.
      3'b110,
      3'b111:  alu_res = exe_b;
`endif
      default: alu_res = 32'd0;
    endcase
  end

  logic        mem_wreg_q, mem_wreg_d;
  logic        mem_m2reg_q, mem_m2reg_d;
  logic        mem_wmem_q, mem_wmem_d;
  logic [31:0] mem_alu_q, mem_alu_d;
  logic [31:0] mem_b_q, mem_b_d;
  logic [4:0]  mem_rn_q, mem_rn_d;
  logic        z_q, z_d;

  always_ff @(posedge clk) begin
    if (clr) begin
      mem_wreg_q  <= 1'b0;
      mem_m2reg_q <= 1'b0;
      mem_wmem_q  <= 1'b0;
      mem_alu_q   <= 32'd0;
      mem_b_q     <= 32'd0;
      mem_rn_q    <= 5'd0;
      z_q         <= 1'b0;
    end else begin
      mem_wreg_q  <= mem_wreg_d;
      mem_m2reg_q <= mem_m2reg_d;
      mem_wmem_q  <= mem_wmem_d;
      mem_alu_q   <= mem_alu_d;
      mem_b_q     <= mem_b_d;
      mem_rn_q    <= mem_rn_d;
      z_q         <= z_d;
    end
  end

  assign mem_wreg  = mem_wreg_q;
  assign mem_m2reg = mem_m2reg_q;
  assign mem_wmem  = mem_wmem_q;
  assign mem_alu   = mem_alu_q;
  assign mem_b     = mem_b_q;
  assign mem_rn    = mem_rn_q;
  assign z         = z_q;

`ifdef SHIFT_FAST_EN
  always_comb begin
    mem_wreg_d  = exe_wreg;
    mem_m2reg_d = exe_m2reg;
    mem_wmem_d  = exe_wmem;
    mem_alu_d   = alu_res;
    mem_b_d     = exe_b;
    mem_rn_d    = exe_rn;
    z_d         = exe_wz ? (alu_res == 32'd0) : z_q;
  end

  assign exe_stall   = 1'b0;
  assign dbg_state_o = 2'b00;
`else
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [4:0] STEP = 5'(SHIFT_STEP);

  state_t      state_q, state_d;
  logic [31:0] acc_q, acc_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] lb_q, lb_d;
  logic [4:0]  lrn_q, lrn_d;
  logic        lwreg_q, lwreg_d;
  logic        lm2reg_q, lm2reg_d;
  logic        lwmem_q, lwmem_d;
  logic        ldir_q, ldir_d;
  logic        lwz_q, lwz_d;
  logic        start;
  logic        stall;
  logic [4:0]  amt;

  assign start = exe_shift & (exe_aluc[2:1] == 2'b11) & (shamt != 5'd0);
  // The last step may be shorter than SHIFT_STEP when shamt is not a multiple of it.
  assign amt   = (cnt_q < STEP) ? cnt_q : STEP;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    lb_d        = lb_q;
    lrn_d       = lrn_q;
    lwreg_d     = lwreg_q;
    lm2reg_d    = lm2reg_q;
    lwmem_d     = lwmem_q;
    ldir_d      = ldir_q;
    lwz_d       = lwz_q;
    stall       = 1'b0;
    mem_wreg_d  = 1'b0;
    mem_m2reg_d = 1'b0;
    mem_wmem_d  = 1'b0;
    mem_alu_d   = mem_alu_q;
    mem_b_d     = mem_b_q;
    mem_rn_d    = mem_rn_q;
    z_d         = z_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          stall    = 1'b1;
          acc_d    = exe_b;
          cnt_d    = shamt;
          lb_d     = exe_b;
          lrn_d    = exe_rn;
          lwreg_d  = exe_wreg;
          lm2reg_d = exe_m2reg;
          lwmem_d  = exe_wmem;
          ldir_d   = exe_aluc[0];
          lwz_d    = exe_wz;
          state_d  = S_SHIFT;
        end else begin
          mem_wreg_d  = exe_wreg;
          mem_m2reg_d = exe_m2reg;
          mem_wmem_d  = exe_wmem;
          mem_alu_d   = alu_res;
          mem_b_d     = exe_b;
          mem_rn_d    = exe_rn;
          z_d         = exe_wz ? (alu_res == 32'd0) : z_q;
        end
      end
      S_SHIFT: begin
        stall = 1'b1;
        acc_d = ldir_q ? (acc_q >> amt) : (acc_q << amt);
        cnt_d = cnt_q - amt;
        if (cnt_q <= STEP) state_d = S_DONE;
      end
      S_DONE: begin
        mem_wreg_d  = lwreg_q;
        mem_m2reg_d = lm2reg_q;
        mem_wmem_d  = lwmem_q;
        mem_alu_d   = acc_q;
        mem_b_d     = lb_q;
        mem_rn_d    = lrn_q;
        z_d         = lwz_q ? (acc_q == 32'd0) : z_q;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q  <= S_IDLE;
      acc_q    <= 32'd0;
      cnt_q    <= 5'd0;
      lb_q     <= 32'd0;
      lrn_q    <= 5'd0;
      lwreg_q  <= 1'b0;
      lm2reg_q <= 1'b0;
      lwmem_q  <= 1'b0;
      ldir_q   <= 1'b0;
      lwz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      lb_q     <= lb_d;
      lrn_q    <= lrn_d;
      lwreg_q  <= lwreg_d;
      lm2reg_q <= lm2reg_d;
      lwmem_q  <= lwmem_d;
      ldir_q   <= ldir_d;
      lwz_q    <= lwz_d;
    end
  end

  // Stall is an upstream hold request; it is valid the same cycle the op is presented.
  assign exe_stall   = stall & ~clr;
  assign dbg_state_o = state_q;
`endif

endmodule

// File: tb/tb_exe_stage.sv
// Bench for exe_stage: directed cases plus random instruction stream against a per-cycle model.
`timescale 1ns/1ps
module tb_exe_stage;
  localparam int STEP = 4;
`ifdef SHIFT_FAST_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  logic        exe_wreg, exe_m2reg, exe_wmem, exe_aluimm, exe_shift, exe_wz;
  logic [2:0]  exe_aluc;
  logic [31:0] exe_a, exe_b, exe_imm;
  logic [4:0]  exe_rn;
  logic        exe_stall, mem_wreg, mem_m2reg, mem_wmem, z;
  logic [31:0] mem_alu, mem_b;
  logic [4:0]  mem_rn;
  logic [1:0]  dbg_state;

  exe_stage #(.SHIFT_STEP(STEP)) dut (
    .clk(clk), .clr(clr),
    .exe_wreg(exe_wreg), .exe_m2reg(exe_m2reg), .exe_wmem(exe_wmem),
    .exe_aluc(exe_aluc), .exe_aluimm(exe_aluimm),
    .exe_a(exe_a), .exe_b(exe_b), .exe_imm(exe_imm), .exe_rn(exe_rn),
    .exe_shift(exe_shift), .exe_wz(exe_wz),
    .exe_stall(exe_stall),
    .mem_wreg(mem_wreg), .mem_m2reg(mem_m2reg), .mem_wmem(mem_wmem),
    .mem_alu(mem_alu), .mem_b(mem_b), .mem_rn(mem_rn), .z(z),
    .dbg_state_o(dbg_state)
  );

  typedef struct packed {
    logic        wreg, m2reg, wmem;
    logic [2:0]  aluc;
    logic        aluimm;
    logic [31:0] a, b, imm;
    logic [4:0]  rn;
    logic        shift, wz;
  } instr_t;

  typedef struct packed {
    logic        stall, wreg, m2reg, wmem;
    logic [31:0] alu, b;
    logic [4:0]  rn;
    logic        z, data_chk;
  } exp_t;

  localparam int EXP_W = $bits(exp_t);
  logic [EXP_W-1:0] exp_q[$];
  exp_t cur;
  int n_checks = 0;
  int n_errors = 0;
  int stall_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // model: architectural result of one instruction
  function automatic logic [31:0] model_result(input instr_t ins);
    logic [31:0] opb;
    logic [4:0]  sh;
    logic [31:0] r;
    opb = ins.aluimm ? ins.imm : ins.b;
    sh  = ins.imm[10:6];
    case (ins.aluc)
      3'b000:  r = ins.a + opb;
      3'b001:  r = ins.a - opb;
      3'b010:  r = ins.a & opb;
      3'b011:  r = ins.a | opb;
      3'b100:  r = ins.a ^ opb;
      3'b101:  r = opb * 32'h0001_0000;
      3'b110:  r = ins.b << sh;
      default: r = ins.b >> sh;
    endcase
    return r;
  endfunction

  function automatic instr_t mk(input logic [2:0] aluc, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] imm, input logic [4:0] rn, input logic wreg,
                                input logic wz, input logic shift, input logic aluimm);
    instr_t ins;
    ins = '0;
    ins.aluc = aluc; ins.a = a; ins.b = b; ins.imm = imm; ins.rn = rn;
    ins.wreg = wreg; ins.wz = wz; ins.shift = shift; ins.aluimm = aluimm;
    return ins;
  endfunction

  function automatic instr_t rand_instr();
    instr_t ins;
    ins = '0;
    if ($urandom_range(0, 7) == 0) return ins;
    ins.wreg   = 1'($urandom);
    ins.m2reg  = 1'($urandom);
    ins.wmem   = 1'($urandom);
    ins.aluc   = 3'($urandom_range(0, 7));
    ins.aluimm = 1'($urandom);
    ins.a      = $urandom;
    ins.b      = ($urandom_range(0, 3) == 0) ? ins.a : $urandom;
    ins.imm    = $urandom;
    ins.rn     = 5'($urandom);
    ins.shift  = 1'($urandom);
    ins.wz     = 1'($urandom);
    if (ins.aluc[2:1] == 2'b11) ins.shift = 1'b1;
    return ins;
  endfunction

  // driver tasks
  task automatic drive(input instr_t ins);
    exe_wreg = ins.wreg; exe_m2reg = ins.m2reg; exe_wmem = ins.wmem;
    exe_aluc = ins.aluc; exe_aluimm = ins.aluimm;
    exe_a = ins.a; exe_b = ins.b; exe_imm = ins.imm; exe_rn = ins.rn;
    exe_shift = ins.shift; exe_wz = ins.wz;
  endtask

  task automatic push(input logic stall);
    exp_t e;
    e = cur;
    e.stall = stall;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(negedge clk);
    if (exe_stall) stall_seen++;
    @(posedge clk);
    #1;
  endtask

  task automatic commit(input instr_t ins);
    logic [31:0] r;
    r = model_result(ins);
    cur.wreg = ins.wreg; cur.m2reg = ins.m2reg; cur.wmem = ins.wmem;
    cur.alu = r; cur.b = ins.b; cur.rn = ins.rn; cur.data_chk = 1'b1;
    if (ins.wz) cur.z = (r == 32'd0);
  endtask

  task automatic bubble_ctrl();
    cur.wreg = 1'b0; cur.m2reg = 1'b0; cur.wmem = 1'b0; cur.data_chk = 1'b0;
  endtask

  function automatic bit is_serial(input instr_t ins);
    return !FAST && ins.shift && (ins.aluc[2:1] == 2'b11) && (ins.imm[10:6] != 5'd0);
  endfunction

  task automatic run_instr(input instr_t ins, input bit scramble);
    int n;
    stall_seen = 0;
    if (is_serial(ins)) begin
      n = (int'(ins.imm[10:6]) + STEP - 1) / STEP + 1;
      for (int i = 0; i < n; i++) begin
        drive((i == 0 || !scramble) ? ins : rand_instr());
        push(1'b1);
        step();
        bubble_ctrl();
      end
    end
    drive(ins);
    push(1'b0);
    step();
    commit(ins);
  endtask

  // scoreboard: every cycle, stall now and the registered outputs from the last edge
  initial begin : cmp
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("stall", 32'(exe_stall), 32'(e.stall));
        chk("mem_wreg", 32'(mem_wreg), 32'(e.wreg));
        chk("mem_m2reg", 32'(mem_m2reg), 32'(e.m2reg));
        chk("mem_wmem", 32'(mem_wmem), 32'(e.wmem));
        chk("z", 32'(z), 32'(e.z));
        if (e.data_chk) begin
          chk("mem_alu", mem_alu, e.alu);
          chk("mem_b", mem_b, e.b);
          chk("mem_rn", 32'(mem_rn), 32'(e.rn));
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
    $fatal(1, "timeout");
  end

  initial begin : drv
    instr_t ins;
    int exp_st;
    cur = '0;
    clr = 1'b1;
    // a live shift on the inputs during reset must not raise stall
    drive(mk(3'b110, 32'd0, 32'd1, 32'd3 << 6, 5'd1, 1'b1, 1'b0, 1'b1, 1'b0));
    repeat (2) @(posedge clk);
    #1;
    cur.data_chk = 1'b1;
    chk("reset_stall", 32'(exe_stall), 32'd0);
    chk("reset_wreg", 32'(mem_wreg), 32'd0);
    chk("reset_alu", mem_alu, 32'd0);
    chk("reset_z", 32'(z), 32'd0);
    clr = 1'b0;

    run_instr(mk(3'b000, 32'd5, 32'hFFFF_FFFB, 32'd0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0), 1'b0);
    chk("add_alu", mem_alu, 32'd0);
    chk("add_rn", 32'(mem_rn), 32'd3);
    chk("add_wreg", 32'(mem_wreg), 32'd1);
    chk("add_z", 32'(z), 32'd1);
    chk("add_stalls", 32'(stall_seen), 32'd0);

    run_instr(mk(3'b110, 32'd0, 32'd1, 32'd3 << 6, 5'd7, 1'b1, 1'b0, 1'b1, 1'b0), 1'b0);
    exp_st = FAST ? 0 : (STEP == 1) ? 4 : (STEP == 2) ? 3 : 2;
    chk("sll_alu", mem_alu, 32'h8);
    chk("sll_wreg", 32'(mem_wreg), 32'd1);
    chk("sll_stalls", 32'(stall_seen), 32'(exp_st));

    run_instr(mk(3'b111, 32'd0, 32'h8000_0000, 32'd31 << 6, 5'd8, 1'b1, 1'b0, 1'b1, 1'b0), 1'b0);
    exp_st = FAST ? 0 : (STEP == 1) ? 32 : (STEP == 2) ? 17 : 9;
    chk("srl_alu", mem_alu, 32'h1);
    chk("srl_stalls", 32'(stall_seen), 32'(exp_st));

    run_instr(mk(3'b110, 32'd0, 32'h1234, 32'd0, 5'd4, 1'b1, 1'b0, 1'b1, 1'b0), 1'b0);
    chk("sll0_alu", mem_alu, 32'h1234);
    chk("sll0_stalls", 32'(stall_seen), 32'd0);

    run_instr(mk(3'b110, 32'd0, 32'h00F0, 32'd2 << 6, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0), 1'b1);
    exp_st = FAST ? 0 : (STEP == 1) ? 3 : 2;
    chk("latched_alu", mem_alu, 32'h3C0);
    chk("latched_b", mem_b, 32'h00F0);
    chk("latched_stalls", 32'(stall_seen), 32'(exp_st));

    run_instr(mk(3'b001, 32'd3, 32'd3, 32'd0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0), 1'b0);
    chk("sub_alu", mem_alu, 32'd0);
    chk("sub_z_kept", 32'(z), 32'd1);
    run_instr(mk(3'b101, 32'd0, 32'd0, 32'h0000_ABCD, 5'd2, 1'b1, 1'b0, 1'b0, 1'b1), 1'b0);
    chk("lui_alu", mem_alu, 32'hABCD_0000);
    run_instr(mk(3'b010, 32'hF0F0, 32'hFF00, 32'd0, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0), 1'b0);
    chk("and_alu", mem_alu, 32'hF000);
    run_instr(mk(3'b011, 32'hF0F0, 32'hFF00, 32'd0, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0), 1'b0);
    chk("or_alu", mem_alu, 32'hFFF0);
    run_instr(mk(3'b100, 32'hF0F0, 32'hFF00, 32'd0, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0), 1'b0);
    chk("xor_alu", mem_alu, 32'h0FF0);

    // reset in the middle of a long shift: nothing may commit afterwards
    ins = mk(3'b110, 32'd0, 32'd5, 32'd20 << 6, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      drive(ins);
      push(is_serial(ins));
      step();
      if (is_serial(ins)) bubble_ctrl();
      else commit(ins);
    end
    clr = 1'b1;
    push(1'b0);
    step();
    cur = '0;
    cur.data_chk = 1'b1;
    push(1'b0);
    step();
    clr = 1'b0;
    drive('0);
    for (int i = 0; i < 40; i++) begin
      push(1'b0);
      step();
      commit('0);
    end
    chk("abort_wreg", 32'(mem_wreg), 32'd0);
    chk("abort_rn", 32'(mem_rn), 32'd0);
    chk("abort_z", 32'(z), 32'd0);

    for (int i = 0; i < 250; i++) run_instr(rand_instr(), 1'($urandom_range(0, 1)));

    drive('0);
    repeat (3) @(posedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
